// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin owner selection for a shared 8:1 mux: registered one-hot grant, mux select and valid.
// Optional macro MUX_GAP_EN inserts one dead cycle (GAP state) between consecutive owners.
module mux_rr_sel_ctrl #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       valid,
    output logic [2:0] ptr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef MUX_GAP_EN
        ST_GAP   = 2'd2,
`endif
        ST_GRANT = 2'd1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state, w_state_next;
    logic [7:0] r_gnt, w_gnt_next;
    logic [2:0] r_s, w_s_next;
    logic       r_valid, w_valid_next;
    logic [2:0] r_ptr, w_ptr_next;
    logic [7:0] r_cnt, w_cnt_next;

    logic [2:0] w_base;
    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_release;

    // While granting, a release searches from the owner's successor so the owner ends up last.
    assign w_base = (r_state == ST_GRANT) ? (r_s + 3'd1) : r_ptr;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign w_rot[gi] = req[w_base + 3'(gi)];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_off   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 3'(k);
            end
        end
    end

    assign w_win     = w_base + w_off;
    assign w_release = (r_state == ST_GRANT) && (!req[r_s] || (r_cnt == HOLD_LAST));

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_s_next     = r_s;
        w_valid_next = r_valid;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_next = r_s + 3'd1;
`ifdef MUX_GAP_EN
                    w_state_next = ST_GAP;
                    w_gnt_next   = 8'd0;
                    w_valid_next = 1'b0;
`else
                    if (w_found) begin
                        w_s_next   = w_win;
                        w_gnt_next = 8'd1 << w_win;
                        w_cnt_next = 8'd0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_gnt_next   = 8'd0;
                        w_valid_next = 1'b0;
                    end
`endif
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                // IDLE and GAP both arbitrate from the stored pointer.
                if (w_found) begin
                    w_state_next = ST_GRANT;
                    w_s_next     = w_win;
                    w_gnt_next   = 8'd1 << w_win;
                    w_valid_next = 1'b1;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = 8'd0;
                    w_valid_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 8'd0;
            r_s     <= 3'd0;
            r_valid <= 1'b0;
            r_ptr   <= 3'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_s     <= w_s_next;
            r_valid <= w_valid_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign gnt   = r_gnt;
    assign s     = r_s;
    assign valid = r_valid;
    assign ptr   = r_ptr;

endmodule
